lcd_stn_capture: RTL and testbench

//  Receive end of the dual-scan monochrome STN panel bus (CL2, CL1, FLM, M, top/bottom data).

---
 rtl/lcd_stn_capture_pkg.sv | 35 +++
 rtl/lcd_stn_capture_sync_edge.sv | 45 ++++
 rtl/lcd_stn_capture.sv | 257 +++++++++++++++++++++++++
 tb/tb_lcd_stn_capture.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_stn_capture_pkg.sv
// ---------------------------------------------------------------------------
// lcd_stn_capture_pkg
// Shared definitions for the STN panel capture block:
//   - default panel geometry (pixels per line, lines per half-panel)
//   - capture FSM state encoding
//   - bit order of the raw panel bus as it enters the synchronizer bank
//   - counter width helper used to size the column/line counters
// No ports; imported by the capture top and its synchronizer sub-module.
// ---------------------------------------------------------------------------
package lcd_stn_capture_pkg;

  localparam int DEFAULT_COLS  = 240;
  localparam int DEFAULT_LINES = 32;

  // SEARCH waits for a first-line marker, CAPTURE tracks the raster.
  typedef enum logic {
    ST_SEARCH  = 1'b0,
    ST_CAPTURE = 1'b1
  } cap_state_t;

  // Position of each panel signal in the synchronizer bank.
  localparam int BUS_CL2  = 0;
  localparam int BUS_CL1  = 1;
  localparam int BUS_FLM  = 2;
  localparam int BUS_M    = 3;
  localparam int BUS_DTOP = 4;
  localparam int BUS_DBOT = 5;
  localparam int BUS_W    = 6;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcd_stn_capture_sync_edge.sv
// ---------------------------------------------------------------------------
// lcd_stn_capture_sync_edge
// Brings one asynchronous panel pin into the system clock domain through a
// chain of SYNC_STAGES flops, then compares against one more flop to give
// single-cycle rise/fall pulses.
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset (chain and history cleared)
//   i_async  raw pin
//   o_level  synchronized level (aligned with the edge pulses)
//   o_rise   1-clk pulse on a synchronized 0->1 transition
//   o_fall   1-clk pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module lcd_stn_capture_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus one history flop for edge detection. Every pin
  // goes through an identical chain, so edges that arrive together on the
  // panel bus also leave here in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/lcd_stn_capture.sv
// ---------------------------------------------------------------------------
// lcd_stn_capture
// Receive side of a dual-scan monochrome STN panel bus. The bus is sampled
// on the system clock, the raster position is rebuilt from CL2/CL1/FLM and
// top/bottom pixels are packed into bytes that are written as pairs into a
// frame-buffer port. Timing and sync faults are flagged with 1-clk pulses.
// Ports:
//   i_clk, i_rst       system clock, asynchronous active-high reset
//   i_cl2              pixel shift clock, data taken on its falling edge
//   i_cl1              line latch, rising edge ends a line
//   i_flm              first-line marker, high during line 0
//   i_m                AC drive polarity, toggles once per frame
//   i_d_top, i_d_bot   top / bottom half pixel data
//   o_wr_en            1-clk frame-buffer write strobe
//   o_wr_addr          line*(COLS/8) + col/8
//   o_wr_data          {bottom byte, top byte}, bit 7 = lowest column
//   o_locked           high while capturing
//   o_frame_done       pulse after the last line of a frame
//   o_col_err          pulse: line ended with a column count other than COLS
//   o_sync_err         pulse: FLM disagrees with the tracked line position
//   o_m_err            pulse: M did not alternate from the previous frame
//   o_frame_cnt        completed frames, wrapping
// ---------------------------------------------------------------------------
module lcd_stn_capture
  import lcd_stn_capture_pkg::*;
#(
  parameter  int COLS        = DEFAULT_COLS,
  parameter  int LINES       = DEFAULT_LINES,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = $clog2(LINES * COLS / 8)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cl2,
  input  logic          i_cl1,
  input  logic          i_flm,
  input  logic          i_m,
  input  logic          i_d_top,
  input  logic          i_d_bot,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [15:0]   o_wr_data,
  output logic          o_locked,
  output logic          o_frame_done,
  output logic          o_col_err,
  output logic          o_sync_err,
  output logic          o_m_err,
  output logic [15:0]   o_frame_cnt
);

  // Column counter must reach COLS itself (saturation/overrun marker).
  localparam int COL_W  = cnt_width(COLS + 1);
  localparam int LINE_W = cnt_width(LINES);
  localparam int GROUPS = COLS / 8;

  logic [BUS_W-1:0] w_bus;
  logic [BUS_W-1:0] w_lvl;
  logic [BUS_W-1:0] w_rise;
  logic [BUS_W-1:0] w_fall;

  logic w_cl2_fall;
  logic w_cl1_rise;
  logic w_flm_rise;
  logic w_flm;
  logic w_m;
  logic w_d_top;
  logic w_d_bot;
  logic w_unused;

  cap_state_t r_state;
  cap_state_t w_state_next;

  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic [7:0]        r_top;
  logic [7:0]        r_bot;

  logic              r_wr_en;
  logic [AW-1:0]     r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_frame_done;
  logic              r_col_err;
  logic              r_sync_err;
  logic              r_m_err;
  logic [15:0]       r_frame_cnt;
  logic              r_m_prev;
  logic              r_m_valid;

  logic              w_active;
  logic              w_cl2_evt;
  logic              w_sync_fault;
  logic              w_shift;
  logic              w_group_done;
  logic              w_line_end;
  logic              w_frame_end;
  logic [COL_W-1:0]  w_col_after;
  logic [AW-1:0]     w_group_addr;

  assign w_bus[BUS_CL2]  = i_cl2;
  assign w_bus[BUS_CL1]  = i_cl1;
  assign w_bus[BUS_FLM]  = i_flm;
  assign w_bus[BUS_M]    = i_m;
  assign w_bus[BUS_DTOP] = i_d_top;
  assign w_bus[BUS_DBOT] = i_d_bot;

  // One synchronizer per pin. Data, M and FLM levels travel through the same
  // depth as the strobes, so the level seen in an event cycle is the level
  // that was on the bus when the strobe edge happened.
  for (genvar gi = 0; gi < BUS_W; gi++) begin : g_sync
    lcd_stn_capture_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_async(w_bus[gi]),
      .o_level(w_lvl[gi]),
      .o_rise (w_rise[gi]),
      .o_fall (w_fall[gi])
    );
  end

  assign w_cl2_fall = w_fall[BUS_CL2];
  assign w_cl1_rise = w_rise[BUS_CL1];
  assign w_flm_rise = w_rise[BUS_FLM];
  assign w_flm      = w_lvl[BUS_FLM];
  assign w_m        = w_lvl[BUS_M];
  assign w_d_top    = w_lvl[BUS_DTOP];
  assign w_d_bot    = w_lvl[BUS_DBOT];

  // Synchronizer outputs this block has no use for.
  assign w_unused = ^{w_lvl[BUS_CL2], w_lvl[BUS_CL1],
                      w_rise[BUS_CL2], w_rise[BUS_M], w_rise[BUS_DTOP], w_rise[BUS_DBOT],
                      w_fall[BUS_CL1], w_fall[BUS_FLM], w_fall[BUS_M],
                      w_fall[BUS_DTOP], w_fall[BUS_DBOT]};

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: lock on a first-line marker, drop lock on a sync fault.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SEARCH:  if (w_flm_rise)   w_state_next = ST_CAPTURE;
      ST_CAPTURE: if (w_sync_fault) w_state_next = ST_SEARCH;
      default:    w_state_next = ST_SEARCH;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_locked = (r_state == ST_CAPTURE);
  end

  // Event decode for the current cycle. A CL2 fall that lands in the same
  // cycle as the FLM rise is already treated as column 0 of line 0, which
  // works because the counters are held at zero throughout SEARCH. The CL2
  // sample is resolved first and the CL1 decision looks at the column count
  // after that sample; a sync fault discards anything CL1 would have done.
  always_comb begin
    w_active     = (r_state == ST_CAPTURE) || w_flm_rise;
    w_cl2_evt    = w_cl2_fall && w_active;
    w_sync_fault = w_cl2_evt && (r_col == '0) && (w_flm != (r_line == '0));
    w_shift      = w_cl2_evt && !w_sync_fault && (r_col != COL_W'(COLS));
    w_group_done = w_shift && (r_col[2:0] == 3'd7);
    w_col_after  = w_shift ? (r_col + COL_W'(1)) : r_col;
    w_line_end   = w_cl1_rise && (r_state == ST_CAPTURE) && !w_sync_fault;
    w_frame_end  = w_line_end && (r_line == LINE_W'(LINES - 1));
    w_group_addr = AW'(r_line) * AW'(GROUPS) + AW'(r_col[COL_W-1:3]);
  end

  // Raster position and pixel shifters. Shifting left with the new pixel at
  // bit 0 leaves the lowest column of each group in bit 7 after 8 samples.
  // A line end clears the shifters so an incomplete group never leaks into
  // the next line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col  <= '0;
      r_line <= '0;
      r_top  <= '0;
      r_bot  <= '0;
    end else if (!w_active || w_sync_fault) begin
      r_col  <= '0;
      r_line <= '0;
      r_top  <= '0;
      r_bot  <= '0;
    end else if (w_line_end) begin
      r_col  <= '0;
      r_top  <= '0;
      r_bot  <= '0;
      r_line <= w_frame_end ? '0 : (r_line + LINE_W'(1));
    end else if (w_shift) begin
      r_col  <= r_col + COL_W'(1);
      r_top  <= {r_top[6:0], w_d_top};
      r_bot  <= {r_bot[6:0], w_d_bot};
    end
  end

  // Write port register: one strobe per completed group, launched the clock
  // after the eighth sample with that group's address and both bytes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_group_done;
      if (w_group_done) begin
        r_wr_addr <= w_group_addr;
        r_wr_data <= {r_bot[6:0], w_d_bot, r_top[6:0], w_d_top};
      end
    end
  end

  // Fault and frame checkers. M is compared against the previous frame end
  // only once a frame has completed since the last lock, so the first frame
  // after acquiring sync never raises m_err.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_done <= 1'b0;
      r_col_err    <= 1'b0;
      r_sync_err   <= 1'b0;
      r_m_err      <= 1'b0;
      r_frame_cnt  <= '0;
      r_m_prev     <= 1'b0;
      r_m_valid    <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      r_col_err    <= w_line_end && (w_col_after != COL_W'(COLS));
      r_sync_err   <= w_sync_fault;
      r_m_err      <= w_frame_end && r_m_valid && (w_m == r_m_prev);
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_m_prev    <= w_m;
        r_m_valid   <= 1'b1;
      end
      if (r_state == ST_SEARCH) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_done = r_frame_done;
  assign o_col_err    = r_col_err;
  assign o_sync_err   = r_sync_err;
  assign o_m_err      = r_m_err;
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_lcd_stn_capture.sv
// ---------------------------------------------------------------------------
// tb_lcd_stn_capture
// Bench for the STN capture block: a panel-bus driver, a line-level model of
// what the capture block should produce, a write scoreboard and pulse
// counters. Geometry is reduced in line count so several frames fit in a
// short run while keeping the full 240-pixel line.
// ---------------------------------------------------------------------------
module tb_lcd_stn_capture;

  localparam int COLS  = 240;
  localparam int LINES = 4;
  localparam int SYNC  = 2;
  localparam int GPL   = COLS / 8;
  localparam int AW    = $clog2(LINES * COLS / 8);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cl2 = 1'b0;
  logic cl1 = 1'b0;
  logic flm = 1'b0;
  logic m = 1'b0;
  logic dTop = 1'b0;
  logic dBot = 1'b0;

  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [15:0]   wrData;
  logic          locked;
  logic          frameDone;
  logic          colErr;
  logic          syncErr;
  logic          mErr;
  logic [15:0]   frameCnt;

  int checks = 0;
  int errors = 0;

  // Model of the expected raster tracking.
  bit mdlLocked = 1'b0;
  int mdlLine = 0;
  int mdlFrames = 0;
  bit mdlMValid = 1'b0;
  bit mdlMPrev = 1'b0;
  int expColErr = 0;
  int expSyncErr = 0;
  int expMErr = 0;
  int expDone = 0;
  int expWrites = 0;

  // Observed activity.
  int seenColErr = 0;
  int seenSyncErr = 0;
  int seenMErr = 0;
  int seenDone = 0;
  int wrCount = 0;
  bit wantFirst = 1'b0;
  logic [AW-1:0] firstAddr = '0;

  logic [AW+15:0] expQ[$];
  logic [AW+15:0] expHead;

  bit topPix[COLS+8];
  bit botPix[COLS+8];

  always #5 clk = ~clk;

  lcd_stn_capture #(
    .COLS(COLS),
    .LINES(LINES),
    .SYNC_STAGES(SYNC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cl2       (cl2),
    .i_cl1       (cl1),
    .i_flm       (flm),
    .i_m         (m),
    .i_d_top     (dTop),
    .i_d_bot     (dBot),
    .o_wr_en     (wrEn),
    .o_wr_addr   (wrAddr),
    .o_wr_data   (wrData),
    .o_locked    (locked),
    .o_frame_done(frameDone),
    .o_col_err   (colErr),
    .o_sync_err  (syncErr),
    .o_m_err     (mErr),
    .o_frame_cnt (frameCnt)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wrEn) begin
        wrCount++;
        if (wantFirst) begin
          firstAddr = wrAddr;
          wantFirst = 1'b0;
        end
        checkOutput("wrPending", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          expHead = expQ.pop_front();
          checkOutput("wrAddr", 32'(wrAddr), 32'(expHead[AW+15:16]));
          checkOutput("wrData", 32'(wrData), 32'(expHead[15:0]));
        end
      end
      if (colErr)    seenColErr++;
      if (syncErr)   seenSyncErr++;
      if (mErr)      seenMErr++;
      if (frameDone) seenDone++;
    end
  end

  // Drives one line of nPix pixels from topPix/botPix and predicts its
  // effect. abortAt >= 0 stops the line before that pixel with no CL1.
  task automatic applyStimulus(input int nPix, input bit flmVal, input bit flmAtFall,
                               input bit joinCl1, input int abortAt);
    bit lineLive;
    logic [7:0] topByte;
    logic [7:0] botByte;
    if (!mdlLocked && flmVal) begin
      mdlLocked = 1'b1;
      mdlLine   = 0;
      mdlMValid = 1'b0;
    end
    lineLive = mdlLocked;
    if (mdlLocked && (flmVal != (mdlLine == 0))) begin
      expSyncErr++;
      mdlLocked = 1'b0;
      mdlLine   = 0;
      lineLive  = 1'b0;
    end
    flm = flmVal && !flmAtFall;
    for (int p = 0; p < nPix; p++) begin
      if (p == abortAt) return;
      dTop = topPix[p];
      dBot = botPix[p];
      cl2  = 1'b1;
      repeat (2) @(negedge clk);
      if (lineLive && (p < COLS) && (p % 8 == 7)) begin
        for (int k = 0; k < 8; k++) begin
          topByte[7-k] = topPix[p-7+k];
          botByte[7-k] = botPix[p-7+k];
        end
        expQ.push_back({AW'(mdlLine * GPL + p / 8), botByte, topByte});
        expWrites++;
      end
      cl2 = 1'b0;
      if ((p == 0) && flmVal && flmAtFall) flm = 1'b1;
      if (joinCl1 && (p == nPix - 1)) cl1 = 1'b1;
      repeat (2) @(negedge clk);
    end
    if (lineLive) begin
      if (((nPix < COLS) ? nPix : COLS) != COLS) expColErr++;
      if (mdlLine == LINES - 1) begin
        mdlLine = 0;
        expDone++;
        mdlFrames++;
        if (mdlMValid && (m == mdlMPrev)) expMErr++;
        mdlMPrev  = m;
        mdlMValid = 1'b1;
      end else begin
        mdlLine++;
      end
    end
    if (!joinCl1) begin
      cl1 = 1'b1;
      repeat (2) @(negedge clk);
    end
    cl1 = 1'b0;
    flm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One frame of LINES lines. Lines named by shortLn/joinLn/overLn get 239
  // pixels, a CL1 coincident with the last CL2 fall, or 3 extra pixels.
  task automatic driveFrame(input bit mVal, input bit flm0, input bit flmAtFall,
                            input int shortLn, input int joinLn, input int overLn,
                            input bit randData, input int abortLn, input int abortPix);
    int n;
    m = mVal;
    for (int ln = 0; ln < LINES; ln++) begin
      for (int c = 0; c < COLS + 8; c++) begin
        if (randData) begin
          topPix[c] = 1'($urandom_range(0, 1));
          botPix[c] = 1'($urandom_range(0, 1));
        end else begin
          topPix[c] = (c % 8 == 0) || (ln % 8 == 0);
          botPix[c] = (c % 8 == 0) || (ln % 8 == 0);
        end
      end
      n = COLS;
      if (ln == shortLn) n = COLS - 1;
      if (ln == overLn)  n = COLS + 3;
      applyStimulus(n, (ln == 0) ? flm0 : 1'b0, flmAtFall && (ln == 0), ln == joinLn,
                    (ln == abortLn) ? abortPix : -1);
      if (ln == abortLn) return;
    end
  endtask

  task automatic checkPhase(input string tag);
    repeat (12) @(negedge clk);
    checkOutput({tag, " queueEmpty"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, " writes"}, 32'(wrCount), 32'(expWrites));
    checkOutput({tag, " colErr"}, 32'(seenColErr), 32'(expColErr));
    checkOutput({tag, " syncErr"}, 32'(seenSyncErr), 32'(expSyncErr));
    checkOutput({tag, " mErr"}, 32'(seenMErr), 32'(expMErr));
    checkOutput({tag, " frameDone"}, 32'(seenDone), 32'(expDone));
    checkOutput({tag, " frameCnt"}, 32'(frameCnt), 32'(mdlFrames & 16'hFFFF));
    checkOutput({tag, " locked"}, 32'(locked), 32'(mdlLocked));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " flags"}, 32'({wrEn, locked, frameDone, colErr, syncErr, mErr}), 32'd0);
    checkOutput({tag, " frameCnt"}, 32'(frameCnt), 32'd0);
    checkOutput({tag, " wrBus"}, 32'({wrAddr, wrData}), 32'd0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Three patterned frames, the first locking with FLM rising on pixel 0's fall.
    driveFrame(1'b0, 1'b1, 1'b1, -1, -1, -1, 1'b0, -1, -1);
    driveFrame(1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b0, -1, -1);
    driveFrame(1'b0, 1'b1, 1'b0, -1, -1, -1, 1'b0, -1, -1);
    checkPhase("pattern");

    // Random data with a short line, a joined CL2/CL1 line and an overrun line.
    driveFrame(1'b1, 1'b1, 1'b0, 1, 2, 3, 1'b1, -1, -1);
    checkPhase("lineEdges");

    // M held constant across frames.
    driveFrame(1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b1, -1, -1);
    checkPhase("mHeld");

    // FLM missing at line 0, then relock and a normal frame.
    driveFrame(1'b0, 1'b0, 1'b0, -1, -1, -1, 1'b1, -1, -1);
    checkPhase("flmMissing");
    driveFrame(1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b1, -1, -1);
    driveFrame(1'b0, 1'b1, 1'b0, -1, -1, -1, 1'b1, -1, -1);
    checkPhase("relock");

    // Reset in the middle of line 2, then relock from scratch.
    driveFrame(1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b1, 2, 100);
    repeat (10) @(negedge clk);
    checkOutput("preReset queueEmpty", 32'(expQ.size()), 32'd0);
    rst = 1'b1;
    #1;
    checkResetOutputs("midReset");
    expQ.delete();
    mdlLocked = 1'b0;
    mdlLine   = 0;
    mdlFrames = 0;
    mdlMValid = 1'b0;
    wantFirst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    driveFrame(1'b0, 1'b1, 1'b0, -1, -1, -1, 1'b1, -1, -1);
    checkPhase("afterReset");
    checkOutput("firstAddrAfterReset", 32'(firstAddr), 32'd0);
    checkOutput("firstWriteSeen", 32'(wantFirst), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Run-length guard.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
